// File: rtl/ysyx_23060171_exec_seq.sv
// Multi-cycle fetch/execute sequencer for the ysyx_23060171 core: one commit per
// instruction, with optional LSU round trip and response timeouts that trap.
module ysyx_23060171_exec_seq #(
  parameter int TO_W   = 10,
  parameter int TO_MAX = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  output logic        ifu_req_valid,
  output logic [31:0] ifu_req_addr,
  input  logic        ifu_req_ready,
  input  logic        ifu_rsp_valid,
  input  logic [31:0] ifu_rsp_data,
  input  logic        ifu_rsp_err,
  output logic [31:0] inst,
  input  logic        is_mem,
  input  logic        is_load,
  input  logic        is_ebreak,
  input  logic        rf_wen_dec,
  output logic        lsu_req_valid,
  input  logic        lsu_req_ready,
  input  logic        lsu_rsp_valid,
  output logic        pc_we,
  output logic        rf_we,
  output logic [31:0] instret,
  output logic        halted,
  output logic        trap
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_WAIT_I   = 3'd2,
    S_EXEC     = 3'd3,
    S_MEM_REQ  = 3'd4,
    S_MEM_WAIT = 3'd5,
    S_HALT     = 3'd6,
    S_TRAP     = 3'd7
  } state_t;

  localparam logic [31:0]     NOP      = 32'h0000_0013;
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TO_MAX);
  localparam logic [TO_W-1:0] TO_SAT   = '1;

  state_t          state_q, state_d;
  logic [31:0]     inst_q, inst_d;
  logic [31:0]     instret_q, instret_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            commit;
  logic [TO_W-1:0] to_cnt_inc;

  assign to_cnt_inc = (to_cnt_q == TO_SAT) ? to_cnt_q : to_cnt_q + TO_W'(1);

  always_comb begin
    state_d       = state_q;
    inst_d        = inst_q;
    to_cnt_d      = to_cnt_q;
    commit        = 1'b0;
    rf_we         = 1'b0;
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    unique case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        ifu_req_valid = 1'b1;
        if (ifu_req_ready) begin
          state_d  = S_WAIT_I;
          to_cnt_d = '0;
        end
      end
      S_WAIT_I: begin
        // A response arriving in the same cycle the limit is reached still wins.
        if (ifu_rsp_valid) begin
          if (ifu_rsp_err) begin
            state_d = S_TRAP;
          end else begin
            inst_d  = ifu_rsp_data;
            state_d = S_EXEC;
          end
        end else if (to_cnt_q == TO_LIMIT) begin
          state_d = S_TRAP;
        end else begin
          to_cnt_d = to_cnt_inc;
        end
      end
      S_EXEC: begin
        if (is_ebreak) begin
          state_d = S_HALT;
        end else if (is_mem) begin
          state_d = S_MEM_REQ;
        end else begin
          commit  = 1'b1;
          rf_we   = rf_wen_dec;
          state_d = S_FETCH;
        end
      end
      S_MEM_REQ: begin
        lsu_req_valid = 1'b1;
        if (lsu_req_ready) begin
          state_d  = S_MEM_WAIT;
          to_cnt_d = '0;
        end
      end
      S_MEM_WAIT: begin
        if (lsu_rsp_valid) begin
          commit  = 1'b1;
          rf_we   = is_load & rf_wen_dec;
          state_d = S_FETCH;
        end else if (to_cnt_q == TO_LIMIT) begin
          state_d = S_TRAP;
        end else begin
          to_cnt_d = to_cnt_inc;
        end
      end
      S_HALT:  state_d = S_HALT;
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_IDLE;
    endcase
    pc_we     = commit;
    instret_d = commit ? instret_q + 32'd1 : instret_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      inst_q    <= NOP;
      instret_q <= 32'd0;
      to_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      inst_q    <= inst_d;
      instret_q <= instret_d;
      to_cnt_q  <= to_cnt_d;
    end
  end

  assign ifu_req_addr = pc;
  assign inst         = inst_q;
  assign instret      = instret_q;
  assign halted       = (state_q == S_HALT);
  assign trap         = (state_q == S_TRAP);

endmodule

// File: tb/tb_ysyx_23060171_exec_seq.sv
// Self-checking bench for ysyx_23060171_exec_seq: table-driven instruction
// vectors plus hand-written reset, timeout and fetch-error sequences.
module tb_ysyx_23060171_exec_seq;

  localparam int TO_W   = 10;
  localparam int TO_MAX = 1000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic        ifu_req_valid;
  logic [31:0] ifu_req_addr;
  logic        ifu_req_ready;
  logic        ifu_rsp_valid;
  logic [31:0] ifu_rsp_data;
  logic        ifu_rsp_err;
  logic [31:0] inst;
  logic        is_mem, is_load, is_ebreak, rf_wen_dec;
  logic        lsu_req_valid, lsu_req_ready, lsu_rsp_valid;
  logic        pc_we, rf_we;
  logic [31:0] instret;
  logic        halted, trap;

  ysyx_23060171_exec_seq #(.TO_W(TO_W), .TO_MAX(TO_MAX)) dut (
    .clk(clk), .rst(rst), .pc(pc),
    .ifu_req_valid(ifu_req_valid), .ifu_req_addr(ifu_req_addr), .ifu_req_ready(ifu_req_ready),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_data(ifu_rsp_data), .ifu_rsp_err(ifu_rsp_err),
    .inst(inst), .is_mem(is_mem), .is_load(is_load), .is_ebreak(is_ebreak), .rf_wen_dec(rf_wen_dec),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_rsp_valid(lsu_rsp_valid),
    .pc_we(pc_we), .rf_we(rf_we), .instret(instret), .halted(halted), .trap(trap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] word;
    logic        mem, load, ebreak, rfw, err;
    int          ifu_rdy_dly, ifu_rsp_dly, lsu_rdy_dly, lsu_rsp_dly;
    logic        exp_commit, exp_rf_we, exp_halt, exp_trap;
  } vec_t;

  typedef struct {
    logic [31:0] inst;
    logic        rf_we;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_instret;
  logic        prev_ifu_pend, prev_lsu_pend;
  logic [31:0] prev_addr;
  vec_t        vecs[8];

  // The pc register of the surrounding core: advances by 4 on each commit.
  always @(posedge clk or posedge rst) begin
    if (rst) pc <= 32'h8000_0000;
    else if (pc_we) pc <= pc + 32'd4;
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Commit monitor and handshake-stability watcher, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      prev_ifu_pend = 1'b0;
      prev_lsu_pend = 1'b0;
    end else begin
      if (prev_ifu_pend) begin
        check_output("ifu_req_valid_held", {31'd0, ifu_req_valid}, 32'd1);
        check_output("ifu_req_addr_held", ifu_req_addr, prev_addr);
      end
      if (prev_lsu_pend) check_output("lsu_req_valid_held", {31'd0, lsu_req_valid}, 32'd1);
      if (pc_we) begin
        if (exp_q.size() == 0) begin
          check_output("unexpected_commit", {31'd0, pc_we}, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check_output("commit_rf_we", {31'd0, rf_we}, {31'd0, mon_e.rf_we});
          check_output("commit_inst", inst, mon_e.inst);
        end
      end else if (rf_we) begin
        check_output("rf_we_without_pc_we", {31'd0, rf_we}, 32'd0);
      end
      prev_ifu_pend = ifu_req_valid && !ifu_req_ready;
      prev_lsu_pend = lsu_req_valid && !lsu_req_ready;
      prev_addr     = ifu_req_addr;
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    ifu_req_ready = 1'b0; ifu_rsp_valid = 1'b0; ifu_rsp_data = 32'd0; ifu_rsp_err = 1'b0;
    lsu_req_ready = 1'b0; lsu_rsp_valid = 1'b0;
    is_mem = 1'b0; is_load = 1'b0; is_ebreak = 1'b0; rf_wen_dec = 1'b0;
    exp_q.delete();
    tick();
    tick();
    rst = 1'b0;
    exp_instret = 32'd0;
    check_output("reset_instret", instret, 32'd0);
    check_output("reset_inst", inst, NOP);
    check_output("reset_halted_trap", {30'd0, halted, trap}, 32'd0);
    check_output("reset_idle_no_req", {29'd0, ifu_req_valid, lsu_req_valid, pc_we}, 32'd0);
    tick();
    check_output("idle_to_fetch", {31'd0, ifu_req_valid}, 32'd1);
  endtask

  // Fetch handshake; leaves the DUT in EXEC (or TRAP on a bus error).
  task automatic do_fetch(input vec_t v);
    int n = 0;
    while (!ifu_req_valid && n < 20) begin
      tick();
      n++;
    end
    check_output("fetch_req_seen", {31'd0, ifu_req_valid}, 32'd1);
    check_output("fetch_addr", ifu_req_addr, pc);
    for (int i = 0; i < v.ifu_rdy_dly; i++) tick();
    ifu_req_ready = 1'b1;
    tick();
    ifu_req_ready = 1'b0;
    for (int i = 0; i < v.ifu_rsp_dly; i++) tick();
    ifu_rsp_valid = 1'b1;
    ifu_rsp_data  = v.word;
    ifu_rsp_err   = v.err;
    is_mem = v.mem; is_load = v.load; is_ebreak = v.ebreak; rf_wen_dec = v.rfw;
    if (v.exp_commit) exp_q.push_back('{inst: v.word, rf_we: v.exp_rf_we});
    tick();
    ifu_rsp_valid = 1'b0;
    ifu_rsp_err   = 1'b0;
  endtask

  // LSU handshake from MEM_REQ through the commit cycle.
  task automatic do_mem(input vec_t v);
    check_output("lsu_req_seen", {31'd0, lsu_req_valid}, 32'd1);
    for (int i = 0; i < v.lsu_rdy_dly; i++) tick();
    lsu_req_ready = 1'b1;
    tick();
    lsu_req_ready = 1'b0;
    for (int i = 0; i < v.lsu_rsp_dly; i++) tick();
    lsu_rsp_valid = 1'b1;
    tick();
    lsu_rsp_valid = 1'b0;
  endtask

  task automatic apply_stimulus(input vec_t v);
    do_fetch(v);
    if (!v.err) begin
      if (v.ebreak) begin
        tick();
      end else if (v.mem) begin
        tick();
        do_mem(v);
      end else begin
        tick();
      end
    end
    if (v.exp_commit) exp_instret = exp_instret + 32'd1;
    check_output("instret", instret, exp_instret);
    check_output("halted", {31'd0, halted}, {31'd0, v.exp_halt});
    check_output("trap", {31'd0, trap}, {31'd0, v.exp_trap});
  endtask

  initial begin
    vec_t v;
    rst = 1'b1;
    //           word           mem  ld   ebr  rfw  err  ird  irs     lrd lrs     cmt  rfwe halt trap
    vecs[0] = '{32'h0010_0093, 1'b0,1'b0,1'b0,1'b1,1'b0, 0, 0,      0, 0,      1'b1,1'b1,1'b0,1'b0};
    vecs[1] = '{32'h0000_a103, 1'b1,1'b1,1'b0,1'b1,1'b0, 2, 3,      3, 2,      1'b1,1'b1,1'b0,1'b0};
    vecs[2] = '{32'h0020_a023, 1'b1,1'b0,1'b0,1'b0,1'b0, 0, 1,      0, 0,      1'b1,1'b0,1'b0,1'b0};
    vecs[3] = '{32'h0020_a223, 1'b1,1'b0,1'b0,1'b1,1'b0, 1, 0,      1, 1,      1'b1,1'b0,1'b0,1'b0};
    vecs[4] = '{32'h0000_0063, 1'b0,1'b0,1'b0,1'b0,1'b0, 0, 2,      0, 0,      1'b1,1'b0,1'b0,1'b0};
    vecs[5] = '{32'h0040_a183, 1'b1,1'b1,1'b0,1'b1,1'b0, 0, 0,      0, TO_MAX, 1'b1,1'b1,1'b0,1'b0};
    vecs[6] = '{32'h0030_0213, 1'b0,1'b0,1'b0,1'b1,1'b0, 0, TO_MAX, 0, 0,      1'b1,1'b1,1'b0,1'b0};
    vecs[7] = '{32'h0010_0073, 1'b0,1'b0,1'b1,1'b0,1'b0, 0, 1,      0, 0,      1'b0,1'b0,1'b1,1'b0};

    do_reset();
    for (int i = 0; i < 8; i++) apply_stimulus(vecs[i]);

    // Halted core must stay quiet even with stray responses on the buses.
    ifu_rsp_valid = 1'b1;
    lsu_rsp_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check_output("halt_quiet", {27'd0, ifu_req_valid, lsu_req_valid, pc_we, rf_we, halted}, 32'd1);
    end
    ifu_rsp_valid = 1'b0;
    lsu_rsp_valid = 1'b0;
    check_output("halt_instret", instret, 32'd7);

    // Fetch bus error traps.
    do_reset();
    v = '{32'hdead_beef, 1'b0,1'b0,1'b0,1'b1,1'b1, 0, 1, 0, 0, 1'b0,1'b0,1'b0,1'b1};
    apply_stimulus(v);
    tick();
    check_output("trap_no_fetch", {30'd0, ifu_req_valid, trap}, 32'd1);

    // Fetch response never arrives: still waiting at TO_MAX, trapped one cycle later.
    do_reset();
    ifu_req_ready = 1'b1;
    tick();
    ifu_req_ready = 1'b0;
    for (int i = 0; i < TO_MAX; i++) tick();
    check_output("timeout_edge_no_trap", {31'd0, trap}, 32'd0);
    tick();
    check_output("timeout_trap", {31'd0, trap}, 32'd1);
    ifu_rsp_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_output("trap_absorbing", {28'd0, ifu_req_valid, pc_we, halted, trap}, 32'd1);
    end
    ifu_rsp_valid = 1'b0;

    // Reset while waiting on a load response; a late response must not commit.
    do_reset();
    apply_stimulus(vecs[0]);
    v = vecs[1];
    v.exp_commit = 1'b0;
    do_fetch(v);
    tick();
    lsu_req_ready = 1'b1;
    tick();
    lsu_req_ready = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    check_output("async_rst_inst", inst, NOP);
    check_output("async_rst_instret", instret, 32'd0);
    check_output("async_rst_strobes", {29'd0, lsu_req_valid, pc_we, rf_we}, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    exp_instret = 32'd0;
    lsu_rsp_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_output("late_rsp_ignored", {30'd0, pc_we, rf_we}, 32'd0);
    end
    lsu_rsp_valid = 1'b0;
    check_output("late_rsp_instret", instret, 32'd0);
    apply_stimulus(vecs[0]);

    tick();
    check_output("scoreboard_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
